// File: rtl/mp3_pkg.sv
// Shared definitions for the MP3 track controller and display.
// Holds the state encoding, the default track count and the wrapping track arithmetic.
package mp3_pkg;

    localparam int TRACK_NUM_DEF = 4;
    localparam int TRACK_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } mp3_state_e;

    // Steps the track index by one and wraps at either end of 0..num-1.
    function automatic logic [TRACK_W-1:0] track_step(
        input logic [TRACK_W-1:0] trk,
        input logic               up,
        input int                 num
    );
        if (up)
            return (int'(trk) >= num - 1) ? '0 : trk + 1'b1;
        else
            return (trk == '0) ? TRACK_W'(num - 1) : trk - 1'b1;
    endfunction

endpackage

// File: rtl/mp3_track_ctrl_if.sv
// Button, decoder handshake and display signals of the track controller.
interface mp3_track_ctrl_if;
    import mp3_pkg::*;

    logic               i_next;
    logic               i_pre;
    logic               i_play;
    logic               i_song_end;
    logic               i_load_ack;
    logic               o_load_req;
    logic [TRACK_W-1:0] o_track;
    logic [1:0]         o_state;
    logic               o_track_chg;

    modport slave (
        input  i_next, i_pre, i_play, i_song_end, i_load_ack,
        output o_load_req, o_track, o_state, o_track_chg
    );

    modport master (
        output i_next, i_pre, i_play, i_song_end, i_load_ack,
        input  o_load_req, o_track, o_state, o_track_chg
    );

endinterface

// File: rtl/mp3_btn_deb.sv
// Raw button conditioning: 2-flop synchronizer, down-counter debounce, rising-edge pulse.
// No pulse is issued until the button has been seen released after reset.
module mp3_btn_deb #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int                CNT_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  RELOAD = (DEB_CYCLES > 2) ? CNT_W'(DEB_CYCLES - 2) : '0;

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_live;
    logic             r_samp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_armed;
    logic             r_pulse;

    // r_live marks when r_sync2 carries a real sample rather than its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_live   <= 2'b00;
            r_samp   <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_armed  <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_live  <= {r_live[0], 1'b1};
            r_pulse <= 1'b0;
            if (r_sync2 != r_samp) begin
                r_samp <= r_sync2;
                r_cnt  <= RELOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_stable <= r_samp;
                if (!r_samp && r_live[1])
                    r_armed <= 1'b1;
                r_pulse <= r_samp & ~r_stable & r_armed;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/mp3_track_ctrl.sv
// Track selection FSM: debounced buttons and decoder handshake drive track index and play state.
// IDLE stopped, track editable | LOAD waiting decoder ack | PLAY playing | PAUSE halted
module mp3_track_ctrl
    import mp3_pkg::*;
#(
    parameter int TRACK_NUM  = TRACK_NUM_DEF,
    parameter int DEB_CYCLES = 1_000_000
) (
    input logic             clk,
    input logic             rst_n,
    mp3_track_ctrl_if.slave bus
);

    logic w_nxt_p;
    logic w_pre_p;
    logic w_play_p;

    mp3_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.i_next),
        .o_pulse (w_nxt_p)
    );

    mp3_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pre (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.i_pre),
        .o_pulse (w_pre_p)
    );

    mp3_btn_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (bus.i_play),
        .o_pulse (w_play_p)
    );

    logic r_nxt_p;
    logic r_pre_p;
    logic r_play_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nxt_p  <= 1'b0;
            r_pre_p  <= 1'b0;
            r_play_p <= 1'b0;
        end else begin
            r_nxt_p  <= w_nxt_p;
            r_pre_p  <= w_pre_p;
            r_play_p <= w_play_p;
        end
    end

    // next+prev together cancel; prev outranks a coincident song end.
    logic w_inc;
    logic w_dec;
    logic [TRACK_W-1:0] w_track_up;
    logic [TRACK_W-1:0] w_track_dn;

    assign w_inc      = r_nxt_p & ~r_pre_p;
    assign w_dec      = r_pre_p & ~r_nxt_p;

    mp3_state_e         r_state;
    mp3_state_e         w_state_nxt;
    logic [TRACK_W-1:0] r_track;
    logic [TRACK_W-1:0] w_track_nxt;
    logic               w_track_upd;
    logic               r_load_req;
    logic               r_track_chg;

    assign w_track_up = track_step(r_track, 1'b1, TRACK_NUM);
    assign w_track_dn = track_step(r_track, 1'b0, TRACK_NUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_track     <= '0;
            r_load_req  <= 1'b0;
            r_track_chg <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_track     <= w_track_nxt;
            r_load_req  <= (w_state_nxt == ST_LOAD);
            r_track_chg <= w_track_upd;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_track_nxt = r_track;
        w_track_upd = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_play_p) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_dec) begin
                    w_track_nxt = w_track_dn;
                    w_track_upd = 1'b1;
                end else if (w_inc) begin
                    w_track_nxt = w_track_up;
                    w_track_upd = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.i_load_ack)
                    w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (r_play_p) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_dec) begin
                    w_track_nxt = w_track_dn;
                    w_track_upd = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else if (w_inc || bus.i_song_end) begin
                    w_track_nxt = w_track_up;
                    w_track_upd = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_PAUSE: begin
                if (r_play_p) begin
                    w_state_nxt = ST_PLAY;
                end else if (w_dec) begin
                    w_track_nxt = w_track_dn;
                    w_track_upd = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_inc) begin
                    w_track_nxt = w_track_up;
                    w_track_upd = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_state     = r_state;
        bus.o_track     = r_track;
        bus.o_load_req  = r_load_req;
        bus.o_track_chg = r_track_chg;
    end

endmodule

// File: tb/tb_mp3_track_ctrl.sv
// Self-checking bench for mp3_track_ctrl with DEB_CYCLES=4, TRACK_NUM=4, 10 ns clock.
module tb_mp3_track_ctrl;
    import mp3_pkg::*;

    localparam int NT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mp3_track_ctrl_if bus_if();

    mp3_track_ctrl #(.TRACK_NUM(NT), .DEB_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: 0=IDLE 1=LOAD 2=PLAY 3=PAUSE
    int m_state = 0;
    int m_track = 0;

    function automatic void model_step(bit nxt, bit pre, bit play, bit send, bit ack);
        if (nxt && pre) begin
            nxt = 1'b0;
            pre = 1'b0;
        end
        case (m_state)
            0: begin
                if (play)     m_state = 1;
                else if (pre) m_track = (m_track + NT - 1) % NT;
                else if (nxt) m_track = (m_track + 1) % NT;
            end
            1: if (ack) m_state = 2;
            2: begin
                if (play)             m_state = 3;
                else if (pre)         begin m_track = (m_track + NT - 1) % NT; m_state = 1; end
                else if (nxt || send) begin m_track = (m_track + 1) % NT;      m_state = 1; end
            end
            default: begin
                if (play)     m_state = 2;
                else if (pre) begin m_track = (m_track + NT - 1) % NT; m_state = 0; end
                else if (nxt) begin m_track = (m_track + 1) % NT;      m_state = 0; end
            end
        endcase
    endfunction

    // Press buttons cleanly for 10 cycles; song_end lands on the cycle the FSM sees the pulse.
    task automatic run_event(input bit nxt, input bit pre, input bit play, input bit send,
                             output int chg_cnt, output int lreq_low);
        @(negedge clk);
        bus_if.i_next = nxt;
        bus_if.i_pre  = pre;
        bus_if.i_play = play;
        chg_cnt  = 0;
        lreq_low = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 7)  bus_if.i_song_end = send;
            if (c == 8)  bus_if.i_song_end = 1'b0;
            if (c == 10) begin
                bus_if.i_next = 1'b0;
                bus_if.i_pre  = 1'b0;
                bus_if.i_play = 1'b0;
            end
            chg_cnt += int'(bus_if.o_track_chg);
            if (!bus_if.o_load_req) lreq_low++;
        end
    endtask

    task automatic pulse_ack;
        @(negedge clk);
        bus_if.i_load_ack = 1'b1;
        @(negedge clk);
        bus_if.i_load_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_op(input int op, output int chg_cnt, output int lreq_low);
        case (op)
            0: begin run_event(1, 0, 0, 0, chg_cnt, lreq_low); model_step(1, 0, 0, 0, 0); end
            1: begin run_event(0, 1, 0, 0, chg_cnt, lreq_low); model_step(0, 1, 0, 0, 0); end
            2: begin run_event(0, 0, 1, 0, chg_cnt, lreq_low); model_step(0, 0, 1, 0, 0); end
            3: begin run_event(0, 0, 0, 1, chg_cnt, lreq_low); model_step(0, 0, 0, 1, 0); end
            4: begin run_event(1, 0, 0, 1, chg_cnt, lreq_low); model_step(1, 0, 0, 1, 0); end
            5: begin run_event(0, 1, 0, 1, chg_cnt, lreq_low); model_step(0, 1, 0, 1, 0); end
            6: begin run_event(1, 1, 0, 0, chg_cnt, lreq_low); model_step(1, 1, 0, 0, 0); end
            default: begin
                pulse_ack();
                model_step(0, 0, 0, 0, 1);
                chg_cnt  = 0;
                lreq_low = 0;
            end
        endcase
    endtask

    task automatic test_reset;
        bus_if.i_next = 0; bus_if.i_pre = 0; bus_if.i_play = 0;
        bus_if.i_song_end = 0; bus_if.i_load_ack = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus_if.o_state, bus_if.o_track, bus_if.o_load_req, bus_if.o_track_chg} !== 8'h00)
            $display("FAIL reset_hold: state=%0d track=%0d lreq=%0b chg=%0b, want all 0",
                     bus_if.o_state, bus_if.o_track, bus_if.o_load_req, bus_if.o_track_chg);
        else n_pass++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        m_state = 0; m_track = 0;
        n_total++;
        if ({bus_if.o_state, bus_if.o_track, bus_if.o_load_req, bus_if.o_track_chg} !== 8'h00)
            $display("FAIL reset_release: state=%0d track=%0d lreq=%0b chg=%0b, want all 0",
                     bus_if.o_state, bus_if.o_track, bus_if.o_load_req, bus_if.o_track_chg);
        else n_pass++;
    endtask

    task automatic test_play_load;
        int chg, low;
        run_event(0, 0, 1, 0, chg, low);
        model_step(0, 0, 1, 0, 0);
        n_total++;
        if (bus_if.o_state !== 2'd1 || bus_if.o_load_req !== 1'b1 || chg != 0)
            $display("FAIL play_enter_load: state=%0d lreq=%0b chg=%0d, want 1/1/0",
                     bus_if.o_state, bus_if.o_load_req, chg);
        else n_pass++;
        repeat (3) @(negedge clk);
        pulse_ack();
        model_step(0, 0, 0, 0, 1);
        n_total++;
        if (bus_if.o_state !== 2'd2 || bus_if.o_load_req !== 1'b0)
            $display("FAIL ack_to_play: state=%0d lreq=%0b, want 2/0", bus_if.o_state, bus_if.o_load_req);
        else n_pass++;
    endtask

    // Sequence: PLAY t0 -> pre(t3,LOAD) ack -> next(t0,LOAD) ack -> play(PAUSE) -> next(t1,IDLE) -> pre(t0) -> pre(t3)
    task automatic test_wrap;
        int ops[8] = '{1, 7, 0, 7, 2, 0, 1, 1};
        int chg, low, prev;
        foreach (ops[k]) begin
            prev = m_track;
            do_op(ops[k], chg, low);
            n_total++;
            if (bus_if.o_state !== 2'(m_state) || bus_if.o_track !== 4'(m_track) ||
                chg != ((prev != m_track) ? 1 : 0))
                $display("FAIL wrap_step%0d: state=%0d track=%0d chg=%0d, want %0d/%0d/%0d", k,
                         bus_if.o_state, bus_if.o_track, chg, m_state, m_track, (prev != m_track) ? 1 : 0);
            else n_pass++;
        end
        n_total++;
        if (bus_if.o_track !== 4'd3 || bus_if.o_state !== 2'd0)
            $display("FAIL wrap_idle_pre: track=%0d state=%0d, want 3/0", bus_if.o_track, bus_if.o_state);
        else n_pass++;
    endtask

    task automatic test_glitch;
        int chg = 0;
        logic [3:0] trk0;
        trk0 = bus_if.o_track;
        @(negedge clk);
        bus_if.i_next = 1; repeat (2) @(negedge clk);
        bus_if.i_next = 0; repeat (1) @(negedge clk);
        bus_if.i_next = 1; repeat (2) @(negedge clk);
        bus_if.i_next = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chg += int'(bus_if.o_track_chg);
        end
        n_total++;
        if (bus_if.o_track !== trk0 || chg != 0 || bus_if.o_state !== 2'(m_state))
            $display("FAIL glitch_next: track=%0d chg=%0d state=%0d, want %0d/0/%0d",
                     bus_if.o_track, chg, bus_if.o_state, trk0, m_state);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        int chg, low, prev;
        do_op(2, chg, low);
        do_op(7, chg, low);
        n_total++;
        if (bus_if.o_state !== 2'd2)
            $display("FAIL simul_setup: state=%0d, want 2", bus_if.o_state);
        else n_pass++;
        prev = m_track;
        do_op(4, chg, low);
        n_total++;
        if (bus_if.o_track !== 4'((prev + 1) % NT) || chg != 1 || bus_if.o_state !== 2'd1)
            $display("FAIL end_with_next: track=%0d chg=%0d state=%0d, want %0d/1/1",
                     bus_if.o_track, chg, bus_if.o_state, (prev + 1) % NT);
        else n_pass++;
        do_op(7, chg, low);
        prev = m_track;
        do_op(6, chg, low);
        n_total++;
        if (bus_if.o_track !== 4'(prev) || chg != 0 || bus_if.o_state !== 2'd2)
            $display("FAIL next_with_pre: track=%0d chg=%0d state=%0d, want %0d/0/2",
                     bus_if.o_track, chg, bus_if.o_state, prev);
        else n_pass++;
        do_op(5, chg, low);
        n_total++;
        if (bus_if.o_track !== 4'((prev + NT - 1) % NT) || chg != 1 || bus_if.o_state !== 2'd1)
            $display("FAIL end_with_pre: track=%0d chg=%0d state=%0d, want %0d/1/1",
                     bus_if.o_track, chg, bus_if.o_state, (prev + NT - 1) % NT);
        else n_pass++;
    endtask

    task automatic test_load_ignore;
        int chg, low;
        logic [3:0] trk0;
        trk0 = bus_if.o_track;
        do_op(0, chg, low);
        n_total++;
        if (bus_if.o_track !== trk0 || chg != 0 || low != 0 || bus_if.o_state !== 2'd1)
            $display("FAIL load_ignore_next: track=%0d chg=%0d lreq_low=%0d state=%0d, want %0d/0/0/1",
                     bus_if.o_track, chg, low, bus_if.o_state, trk0);
        else n_pass++;
        do_op(3, chg, low);
        n_total++;
        if (bus_if.o_track !== trk0 || chg != 0 || low != 0)
            $display("FAIL load_ignore_end: track=%0d chg=%0d lreq_low=%0d, want %0d/0/0",
                     bus_if.o_track, chg, low, trk0);
        else n_pass++;
        do_op(7, chg, low);
        n_total++;
        if (bus_if.o_state !== 2'd2 || bus_if.o_load_req !== 1'b0)
            $display("FAIL load_ack_after_ignore: state=%0d lreq=%0b, want 2/0", bus_if.o_state, bus_if.o_load_req);
        else n_pass++;
    endtask

    task automatic test_reset_in_load;
        int chg = 0;
        int c0, l0;
        do_op(0, c0, l0);
        n_total++;
        if (bus_if.o_load_req !== 1'b1)
            $display("FAIL rst_load_setup: lreq=%0b, want 1", bus_if.o_load_req);
        else n_pass++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus_if.o_load_req !== 1'b0 || bus_if.o_state !== 2'd0)
            $display("FAIL rst_async_drop: lreq=%0b state=%0d, want 0/0", bus_if.o_load_req, bus_if.o_state);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        m_state = 0; m_track = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chg += int'(bus_if.o_track_chg);
        end
        n_total++;
        if (bus_if.o_state !== 2'd0 || bus_if.o_track !== 4'd0 || chg != 0 || bus_if.o_load_req !== 1'b0)
            $display("FAIL rst_release_idle: state=%0d track=%0d chg=%0d lreq=%0b, want 0/0/0/0",
                     bus_if.o_state, bus_if.o_track, chg, bus_if.o_load_req);
        else n_pass++;
    endtask

    task automatic test_held_reset;
        int chg, low;
        bus_if.i_play = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_state = 0; m_track = 0;
        repeat (20) @(negedge clk);
        n_total++;
        if (bus_if.o_state !== 2'd0 || bus_if.o_load_req !== 1'b0)
            $display("FAIL held_through_reset: state=%0d lreq=%0b, want 0/0", bus_if.o_state, bus_if.o_load_req);
        else n_pass++;
        bus_if.i_play = 1'b0;
        repeat (20) @(negedge clk);
        n_total++;
        if (bus_if.o_state !== 2'd0)
            $display("FAIL held_release: state=%0d, want 0", bus_if.o_state);
        else n_pass++;
        do_op(2, chg, low);
        n_total++;
        if (bus_if.o_state !== 2'd1 || bus_if.o_load_req !== 1'b1)
            $display("FAIL repress_after_reset: state=%0d lreq=%0b, want 1/1", bus_if.o_state, bus_if.o_load_req);
        else n_pass++;
    endtask

    task automatic test_random;
        int chg, low, prev, op;
        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 8));
            prev = m_track;
            do_op(op, chg, low);
            n_total++;
            if (bus_if.o_state !== 2'(m_state) || bus_if.o_track !== 4'(m_track) ||
                chg != ((prev != m_track) ? 1 : 0) || bus_if.o_load_req !== (m_state == 1))
                $display("FAIL random%0d_op%0d: state=%0d track=%0d chg=%0d lreq=%0b, want %0d/%0d/%0d/%0b",
                         k, op, bus_if.o_state, bus_if.o_track, chg, bus_if.o_load_req,
                         m_state, m_track, (prev != m_track) ? 1 : 0, m_state == 1);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_play_load();
        test_wrap();
        test_glitch();
        test_simultaneous();
        test_load_ignore();
        test_reset_in_load();
        test_held_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL timeout: run still active at 2 ms, want finished");
        $fatal(1, "timeout");
    end

endmodule
